fetch_queue: RTL

- Parametrised instruction-fetch front end. Replaces the single-entry PC register plus IF/ID latch with a PC generator feeding a DEPTH-entry prefetch FIFO.
- Sits between the datapath_cache_if instruction port and the ID stage. Decode consumes {instr, pcplus4} pairs while fetch keeps running ahead through stalls.
- Branch/jump redirect from ID flushes all prefetched entries and restarts fetch at the target.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_queue.sv | 75 +++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and instruction-fetch queue entry.
package cpu_types_pkg;

    localparam int unsigned WORD_W           = 32;
    localparam int unsigned FQ_DEPTH_DEFAULT = 4;

    typedef logic [WORD_W-1:0] word_t;

    // One prefetched instruction together with the PC of its successor.
    typedef struct packed {
        word_t instr;
        word_t pcplus4;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic first-word-fall-through FIFO with synchronous clear; DEPTH must be a power of two >= 2.
module fetch_fifo
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH   = FQ_DEPTH_DEFAULT,
    parameter type         entry_t = fq_entry_t,
    parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  entry_t           wdata,
    output entry_t           rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head is presented straight from storage; zero while empty so stale data never leaks.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only observed once counted valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC generator feeding a prefetch FIFO that ID drains.
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter word_t       PC_INIT = 32'h0,
    parameter int unsigned DEPTH   = FQ_DEPTH_DEFAULT,
    parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    output logic             imemREN,
    output word_t            imemaddr,
    input  word_t            imemload,
    input  logic             ihit,
    input  logic             redirect,
    input  word_t            redirect_pc,
    input  logic             halt,
    input  logic             deq,
    output logic             valid_out,
    output word_t            instr_out,
    output word_t            pcplus4_out,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    word_t     fetch_pc;
    word_t     pc_plus4;
    logic      empty;
    logic      push;
    logic      pop;
    fq_entry_t wr_entry;
    fq_entry_t head;

    assign pc_plus4 = fetch_pc + 32'd4;
    assign imemREN  = !full && !halt;
    assign imemaddr = fetch_pc;

    // Redirect dominates: the ihit and deq of a redirect cycle are dropped.
    assign push = ihit && imemREN && !redirect;
    assign pop  = deq && valid_out && !redirect;

    assign wr_entry = '{instr: imemload, pcplus4: pc_plus4};

    assign valid_out   = !empty;
    assign instr_out   = head.instr;
    assign pcplus4_out = head.pcplus4;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_pc <= PC_INIT;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
        end else if (push) begin
            fetch_pc <= pc_plus4;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fq_entry_t),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .clear (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule
